instr_fetch_ctrl: RTL

Instruction fetch controller sitting directly upstream of the IF/ID pipeline register. It owns the program counter and drives the synchronous 512x32 instruction memory (1-cycle read latency). It also provides a host program-load mode that writes words into that memory before execution. It presents one instruction per cycle to the IF/ID register with a valid flag, honours a stall from hazard logic, and stops on a halt word.

---
 rtl/instr_fetch_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the program counter, drives a synchronous instruction
// memory (1-cycle read latency) and presents one instruction per cycle to IF/ID.
// Also provides a host program-load path into the same memory.
// Optional feature macro: HALT_DETECT_EN enables halt-word detection and the
// HALT state; without it the halt encoding is an ordinary instruction.
module instr_fetch_ctrl #(
    parameter int unsigned       ADDR_W    = 9,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_en_i,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_pc_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              imem_we_o,
    output logic [DATA_W-1:0] imem_din_o,
    input  logic [DATA_W-1:0] imem_dout_i,
    output logic [DATA_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic              if_valid_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic [15:0]       fetch_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;       // next address to issue
    logic [ADDR_W-1:0] cur_pc_q, cur_pc_d; // address of the word on imem_dout
    logic [15:0]       cnt_q, cnt_d;
    logic              halt_seen;
    logic              deliver;

`ifdef HALT_DETECT_EN
    // The word currently returned by memory is the halt encoding.
    assign halt_seen = (imem_dout_i == HALT_WORD);
    assign halted_o  = (state_q == S_HALT);
`else
    assign halt_seen = 1'b0;
    assign halted_o  = 1'b0;
`endif

    assign busy_o        = (state_q == S_PRIME) || (state_q == S_RUN);
    assign fetch_count_o = cnt_q;

    // State, PC and delivery counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cur_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cur_pc_q <= cur_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, memory port and IF/ID output decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cur_pc_d    = cur_pc_q;
        cnt_d       = cnt_q;
        deliver     = 1'b0;
        imem_addr_o = '0;
        imem_we_o   = 1'b0;
        imem_din_o  = '0;
        if_instr_o  = '0;
        if_pc_o     = '0;
        if_valid_o  = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                // Load takes priority over a simultaneous start.
                if (load_en_i) begin
                    state_d = S_LOAD;
                end else if (start_i) begin
                    state_d = S_PRIME;
                    pc_d    = start_pc_i;
                    cnt_d   = '0;
                end
            end

            S_LOAD: begin
                imem_addr_o = load_addr_i;
                imem_din_o  = load_data_i;
                imem_we_o   = load_we_i;
                if (!load_en_i) state_d = S_IDLE;
            end

            S_PRIME: begin
                // Issue the first read so RUN starts with valid data.
                imem_addr_o = pc_q;
                cur_pc_d    = pc_q;
                pc_d        = pc_q + 1'b1;
                state_d     = S_RUN;
            end

            S_RUN: begin
                if_instr_o = imem_dout_i;
                if_pc_o    = cur_pc_q;
                deliver    = !stall_i && !halt_seen;
                if_valid_o = deliver;
                if (stall_i) begin
                    // Re-read the current word so imem_dout stays put.
                    imem_addr_o = cur_pc_q;
                end else begin
                    imem_addr_o = pc_q;
                    cur_pc_d    = pc_q;
                    pc_d        = pc_q + 1'b1;
                end
                if (halt_seen) state_d = S_HALT;
                if (deliver && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
